score_arbiter: RTL and testbench

- Arbitrates and sequences score-change events from the per-column hit detectors into one saturating total score.
- Replaces the unguarded four-way parallel add in the top level with one granted event per clock.
- Owns total_score and the game-over (stop) flag consumed by the column shifters, LED mapper and score display.
- Runs on the divided game clock.

---
 rtl/score_arbiter.sv | 142 ++++++++++++++
 tb/tb_score_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/score_arbiter.sv
// score_arbiter: round-robin sequencer of per-column score events into one
// saturating total score with a sticky game-over (stop) flag.
// Ports: clk, reset (async, active-low), clear (sync restart),
//        req/delta (per-column events), ack (one-hot consumed pulse),
//        total_score, stop, streak.
// Optional build macro SCORE_STREAK_EN: positive-event streak counter and
// doubled delta once the streak reaches STREAK_TH.
module score_arbiter #(
    parameter int NUM_COLS  = 4,
    parameter int SCORE_W   = 8,
    parameter int DELTA_W   = 8,
    parameter int MAX_SCORE = 255,
    parameter int STREAK_TH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [NUM_COLS-1:0]         req,
    input  logic [NUM_COLS*DELTA_W-1:0] delta,
    output logic [NUM_COLS-1:0]         ack,
    output logic [SCORE_W-1:0]          total_score,
    output logic                        stop,
    output logic [3:0]                  streak
);

    localparam int PTR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int SUM_W = SCORE_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_SCORE);
    localparam logic [PTR_W:0] NC = (PTR_W + 1)'(NUM_COLS);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_COLS - 1);

    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_next;
    logic [PTR_W-1:0]          gnt_idx;
    logic                      gnt_vld;
    logic [NUM_COLS-1:0]       eligible;
    logic [DELTA_W-1:0]        gnt_delta;
    logic signed [SUM_W-1:0]   delta_ext;
    logic signed [SUM_W-1:0]   add_val;
    logic signed [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0]        score_next;
    logic                      hit_max;

    // A column acked this cycle is still holding req; mask it so the
    // same event is never granted twice.
    assign eligible = req & ~ack;

    always_comb begin
        logic [PTR_W:0]   idx_w;
        logic [PTR_W-1:0] idx;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        gnt_delta = '0;
        idx_w     = '0;
        idx       = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            idx_w = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (idx_w >= NC) begin
                idx_w = idx_w - NC;
            end
            idx = idx_w[PTR_W-1:0];
            if (!gnt_vld && eligible[idx]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = idx;
                gnt_delta = delta[idx*DELTA_W +: DELTA_W];
            end
        end
    end

    assign ptr_next  = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
    assign delta_ext = {{(SUM_W - DELTA_W){gnt_delta[DELTA_W-1]}}, gnt_delta};

`ifdef SCORE_STREAK_EN
    logic [3:0] streak_q;
    logic       pos;

    assign pos     = !gnt_delta[DELTA_W-1] && (|gnt_delta);
    // Threshold is judged on the streak before this event updates it.
    assign add_val = (pos && streak_q >= 4'(STREAK_TH)) ? (delta_ext <<< 1)
                                                         : delta_ext;
    assign streak  = streak_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else if (clear) begin
            streak_q <= '0;
        end else if (gnt_vld && !stop) begin
            if (pos) begin
                streak_q <= (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_q <= '0;
            end
        end
    end
`else
    assign add_val = delta_ext;
    assign streak  = 4'd0;
`endif

    assign sum = $signed({2'b00, total_score}) + add_val;

    always_comb begin
        hit_max    = 1'b0;
        score_next = sum[SCORE_W-1:0];
        if (sum[SUM_W-1]) begin
            score_next = '0;
        end else if (sum >= MAX_S) begin
            score_next = SCORE_W'(MAX_SCORE);
            hit_max    = 1'b1;
        end
    end

    // clear outranks a grant: no ack, so the request stays pending.
    // Once stopped, events are still consumed but the score is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_score <= '0;
            stop        <= 1'b0;
            ack         <= '0;
            ptr         <= '0;
        end else if (clear) begin
            total_score <= '0;
            stop        <= 1'b0;
            ack         <= '0;
            ptr         <= '0;
        end else begin
            ack <= '0;
            if (gnt_vld) begin
                ack <= NUM_COLS'(1) << gnt_idx;
                ptr <= ptr_next;
                if (!stop) begin
                    total_score <= score_next;
                    if (hit_max) begin
                        stop <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter: hand-computed scores, acks and stop.
// Define SCORE_STREAK_EN on both files to exercise the streak bonus.
module tb_score_arbiter;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [3:0]  req;
    logic [31:0] delta;
    logic [3:0]  ack;
    logic [7:0]  total_score;
    logic        stop;
    logic [3:0]  streak;

    int errors = 0;
    int checks = 0;

    score_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .req         (req),
        .delta       (delta),
        .ack         (ack),
        .total_score (total_score),
        .stop        (stop),
        .streak      (streak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single isolated event: grant, ack one cycle later, then the held
    // request must not be granted again during the ack cycle.
    task automatic ev(input int col, input logic [7:0] d,
                      input logic [7:0] es, input logic est,
                      input string tag);
        logic [3:0] ea;
        ea = 4'(1 << col);
        req[col] = 1'b1;
        delta[col*8 +: 8] = d;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'(ea));
        check({tag, "_score"}, 32'(total_score), 32'(es));
        check({tag, "_stop"}, 32'(stop), 32'(est));
        tick();
        check({tag, "_noack"}, 32'(ack), 32'd0);
        check({tag, "_hold"}, 32'(total_score), 32'(es));
        req[col] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        req   = '0;
        delta = '0;
        tick();
        check("rst_score", 32'(total_score), 32'd0);
        check("rst_stop", 32'(stop), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_streak", 32'(streak), 32'd0);
        reset = 1'b1;
        tick();

        // single +5 on col0; ptr -> 1
        ev(0, 8'd5, 8'd5, 1'b0, "t1");

        // restart to bring ptr back to 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_score", 32'(total_score), 32'd0);

        // all four columns, +1 each, served in order
        delta = 32'h0101_0101;
        req   = 4'b1111;
        tick();
        check("rr0_ack", 32'(ack), 32'h1);
        check("rr0_score", 32'(total_score), 32'd1);
        tick();
        check("rr1_ack", 32'(ack), 32'h2);
        check("rr1_score", 32'(total_score), 32'd2);
        req = 4'b1110;
        tick();
        check("rr2_ack", 32'(ack), 32'h4);
        check("rr2_score", 32'(total_score), 32'd3);
        req = 4'b1100;
        tick();
        check("rr3_ack", 32'(ack), 32'h8);
        check("rr3_score", 32'(total_score), 32'd4);
        req = 4'b1000;
        tick();
        check("rr_idle_ack", 32'(ack), 32'h0);
        check("rr_idle_score", 32'(total_score), 32'd4);
        req = 4'b0000;

        // ptr must be 0: col0 wins over col3; col0 -1, col3 zero delta
        delta = {8'd0, 8'd0, 8'd0, 8'hFF};
        req   = 4'b1001;
        tick();
        check("ptr0_ack", 32'(ack), 32'h1);
        check("ptr0_score", 32'(total_score), 32'd3);
        tick();
        check("zero_ack", 32'(ack), 32'h8);
        check("zero_score", 32'(total_score), 32'd3);
        req = 4'b1000;
        tick();
        check("zero_noack", 32'(ack), 32'h0);
        req = 4'b0000;

        // 3 - 10 floors at 0
        ev(2, 8'hF6, 8'd0, 1'b0, "neg");

        // climb to 250, then overshoot to the ceiling
        ev(1, 8'd127, 8'd127, 1'b0, "up1");
        ev(1, 8'd123, 8'd250, 1'b0, "up2");
        ev(1, 8'd9, 8'd255, 1'b1, "sat");
        ev(0, 8'd1, 8'd255, 1'b1, "frz_p");
        ev(2, 8'hFF, 8'd255, 1'b1, "frz_n");

        // clear beats a simultaneous col3 request
        clear = 1'b1;
        req   = 4'b1000;
        delta[31:24] = 8'd4;
        tick();
        clear = 1'b0;
        check("clr_noack", 32'(ack), 32'h0);
        check("clr_score0", 32'(total_score), 32'd0);
        check("clr_stop0", 32'(stop), 32'd0);
        tick();
        check("clr_ack3", 32'(ack), 32'h8);
        check("clr_score4", 32'(total_score), 32'd4);
        tick();
        check("clr_noack2", 32'(ack), 32'h0);
        req = 4'b0000;

`ifdef SCORE_STREAK_EN
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("stk_clr", 32'(streak), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            ev(0, 8'd1, 8'(i), 1'b0, "stk");
        end
        check("stk8", 32'(streak), 32'd8);
        ev(0, 8'd1, 8'd10, 1'b0, "bonus");
        check("stk9", 32'(streak), 32'd9);
        ev(0, 8'hFF, 8'd9, 1'b0, "brk");
        check("stk_brk", 32'(streak), 32'd0);
`else
        check("stk_off", 32'(streak), 32'd0);
`endif

        // async reset drops a pending ack without a clock edge
        req = 4'b0001;
        delta[7:0] = 8'd2;
        tick();
        check("ar_ack", 32'(ack), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_ack0", 32'(ack), 32'h0);
        check("ar_score0", 32'(total_score), 32'd0);
        req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
